// File: rtl/bird_collision_detector.sv
// Frame-based bird collision/score judge with a game-phase FSM (IDLE/PLAY/CRASHED).
// Optional macro BIRD_INVINCIBLE_EN: pipe overlaps no longer cause a crash (floor still does).
module bird_collision_detector #(
   parameter int MIN_PIXELS = 4,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       gameActive,
   input  logic       birdDR,
   input  logic [3:0] birdEdge,
   input  logic       pipeDR,
   input  logic       floorDR,
   input  logic       scoreDR,
   output logic       collision,
   output logic [3:0] collisionEdge,
   output logic       hitFloor,
   output logic       scorePulse,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, CRASHED = 2'd2} phase_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   phase_t           r_phase;
   logic [CNT_W-1:0] r_overlapCnt;
   logic [3:0]       r_edgeAcc;
   logic             r_floorSeen;
   logic             r_scoreSeen;
   logic             r_prevScore;
   logic             r_collision;
   logic [3:0]       r_collisionEdge;
   logic             r_hitFloor;
   logic             r_scorePulse;

   logic w_pipeHit;
   logic w_floorHit;
   logic w_scoreHit;
   logic w_crash;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != CNT_MAX))
         return v + CNT_W'(1);
      return v;
   endfunction

   assign w_pipeHit  = birdDR & pipeDR;
   assign w_floorHit = birdDR & floorDR;
   assign w_scoreHit = birdDR & scoreDR;

`ifdef BIRD_INVINCIBLE_EN
   assign w_crash = r_floorSeen;
`else
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
   assign w_crash = (r_overlapCnt >= MIN_CNT) | r_floorSeen;
`endif

   // The pixel on the startOfFrame cycle opens the new frame, so accumulators
   // are reloaded from it rather than simply zeroed.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_phase         <= IDLE;
         r_overlapCnt    <= '0;
         r_edgeAcc       <= '0;
         r_floorSeen     <= 1'b0;
         r_scoreSeen     <= 1'b0;
         r_prevScore     <= 1'b0;
         r_collision     <= 1'b0;
         r_collisionEdge <= '0;
         r_hitFloor      <= 1'b0;
         r_scorePulse    <= 1'b0;
      end else begin
         r_collision  <= 1'b0;
         r_hitFloor   <= 1'b0;
         r_scorePulse <= 1'b0;
         case (r_phase)
            IDLE: begin
               if (gameActive && startOfFrame) begin
                  r_phase      <= PLAY;
                  r_overlapCnt <= sat_inc('0, w_pipeHit);
                  r_edgeAcc    <= (w_pipeHit | w_floorHit) ? birdEdge : 4'h0;
                  r_floorSeen  <= w_floorHit;
                  r_scoreSeen  <= w_scoreHit;
               end
            end
            PLAY: begin
               if (!gameActive) begin
                  r_phase         <= IDLE;
                  r_overlapCnt    <= '0;
                  r_edgeAcc       <= '0;
                  r_floorSeen     <= 1'b0;
                  r_scoreSeen     <= 1'b0;
                  r_prevScore     <= 1'b0;
                  r_collisionEdge <= '0;
               end else if (startOfFrame) begin
                  if (w_crash) begin
                     r_collision     <= 1'b1;
                     r_hitFloor      <= r_floorSeen;
                     r_collisionEdge <= r_edgeAcc;
                     r_phase         <= CRASHED;
                  end else if (r_scoreSeen && !r_prevScore) begin
                     r_scorePulse <= 1'b1;
                  end
                  r_prevScore  <= r_scoreSeen;
                  r_overlapCnt <= sat_inc('0, w_pipeHit);
                  r_edgeAcc    <= (w_pipeHit | w_floorHit) ? birdEdge : 4'h0;
                  r_floorSeen  <= w_floorHit;
                  r_scoreSeen  <= w_scoreHit;
               end else begin
                  r_overlapCnt <= sat_inc(r_overlapCnt, w_pipeHit);
                  r_edgeAcc    <= r_edgeAcc | ((w_pipeHit | w_floorHit) ? birdEdge : 4'h0);
                  r_floorSeen  <= r_floorSeen | w_floorHit;
                  r_scoreSeen  <= r_scoreSeen | w_scoreHit;
               end
            end
            CRASHED: begin
               // Accumulators stay frozen; collisionEdge is held until the round ends.
               if (!gameActive) begin
                  r_phase         <= IDLE;
                  r_overlapCnt    <= '0;
                  r_edgeAcc       <= '0;
                  r_floorSeen     <= 1'b0;
                  r_scoreSeen     <= 1'b0;
                  r_prevScore     <= 1'b0;
                  r_collisionEdge <= '0;
               end
            end
            default: r_phase <= IDLE;
         endcase
      end
   end

   assign collision     = r_collision;
   assign collisionEdge = r_collisionEdge;
   assign hitFloor      = r_hitFloor;
   assign scorePulse    = r_scorePulse;
   assign phase         = r_phase;

`ifndef SYNTHESIS
   a_min_pixels_range: assert property (@(posedge clk)
      (MIN_PIXELS >= 1) && (MIN_PIXELS <= (1 << CNT_W) - 1));
`endif

endmodule

// File: tb/tb_bird_collision_detector.sv
// Scoreboard bench for bird_collision_detector (default build, MIN_PIXELS=4, CNT_W=8).
module tb_bird_collision_detector;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       gameActive = 1'b0;
   logic       birdDR = 1'b0;
   logic [3:0] birdEdge = 4'h0;
   logic       pipeDR = 1'b0;
   logic       floorDR = 1'b0;
   logic       scoreDR = 1'b0;
   logic       collision;
   logic [3:0] collisionEdge;
   logic       hitFloor;
   logic       scorePulse;
   logic [1:0] phase;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       col;
      logic       flr;
      logic [3:0] edg;
      logic       scr;
   } ev_t;

   ev_t  q[$];
   ev_t  mon_e;
   logic sof_q = 1'b0;

   always #5 clk = ~clk;

   bird_collision_detector #(.MIN_PIXELS(4), .CNT_W(8)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameActive(gameActive),
      .birdDR(birdDR), .birdEdge(birdEdge), .pipeDR(pipeDR), .floorDR(floorDR),
      .scoreDR(scoreDR), .collision(collision), .collisionEdge(collisionEdge),
      .hitFloor(hitFloor), .scorePulse(scorePulse), .phase(phase)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: any event must follow a startOfFrame cycle and match the queue head.
   always @(posedge clk) sof_q <= startOfFrame;

   always @(negedge clk) begin
      if (resetN && (collision || scorePulse)) begin
         check("event_after_sof", {31'd0, sof_q}, 32'd1);
         if (q.size() == 0) begin
            check("unexpected_event", {30'd0, collision, scorePulse}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check("collision", {31'd0, collision}, {31'd0, mon_e.col});
            check("hitFloor", {31'd0, hitFloor}, {31'd0, mon_e.flr});
            check("scorePulse", {31'd0, scorePulse}, {31'd0, mon_e.scr});
            if (mon_e.col)
               check("collisionEdge", {28'd0, collisionEdge}, {28'd0, mon_e.edg});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic pix(input logic b, input logic [3:0] e, input logic p, input logic f,
                      input logic s);
      birdDR = b; birdEdge = e; pipeDR = p; floorDR = f; scoreDR = s;
      step();
      birdDR = 1'b0; birdEdge = 4'h0; pipeDR = 1'b0; floorDR = 1'b0; scoreDR = 1'b0;
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
   endtask

   task automatic expect_ev(input logic c, input logic f, input logic [3:0] e, input logic s);
      ev_t ev;
      ev.col = c; ev.flr = f; ev.edg = e; ev.scr = s;
      q.push_back(ev);
   endtask

   task automatic restart();
      gameActive = 1'b0;
      idle(2);
      gameActive = 1'b1;
      idle(2);
      sof();
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(3);
      check("rst_collision", {31'd0, collision}, 32'd0);
      check("rst_edge", {28'd0, collisionEdge}, 32'd0);
      check("rst_hitFloor", {31'd0, hitFloor}, 32'd0);
      check("rst_scorePulse", {31'd0, scorePulse}, 32'd0);
      check("rst_phase", {30'd0, phase}, 32'd0);
      resetN = 1'b1;
      gameActive = 1'b1;
      idle(3);
      check("idle_waits_sof", {30'd0, phase}, 32'd0);
      sof();
      check("enter_play", {30'd0, phase}, 32'd1);

      // 3 overlapping pixels: below threshold
      repeat (3) begin pix(1'b1, 4'h8, 1'b1, 1'b0, 1'b0); idle(1); end
      sof();
      idle(2);
      check("three_px_phase", {30'd0, phase}, 32'd1);
      check("three_px_drain", q.size(), 32'd0);

      // 5 overlapping pixels with two edges
      repeat (2) pix(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
      repeat (3) pix(1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
      idle(2);
      expect_ev(1'b1, 1'b0, 4'hC, 1'b0);
      sof();
      idle(2);
      check("pipe_crash_phase", {30'd0, phase}, 32'd2);
      check("pipe_crash_drain", q.size(), 32'd0);

      // Further overlaps while crashed: no events, edge held
      repeat (6) pix(1'b1, 4'h1, 1'b1, 1'b1, 1'b1);
      sof();
      idle(2);
      check("crashed_edge_held", {28'd0, collisionEdge}, 32'hC);
      check("crashed_phase", {30'd0, phase}, 32'd2);

      gameActive = 1'b0;
      idle(1);
      check("drop_phase", {30'd0, phase}, 32'd0);
      check("drop_edge", {28'd0, collisionEdge}, 32'd0);

      // Raise mid-frame: partial frame with 5 overlaps must never be judged
      gameActive = 1'b1;
      repeat (5) pix(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
      sof();
      idle(2);
      check("midframe_phase", {30'd0, phase}, 32'd1);
      check("midframe_drain", q.size(), 32'd0);
      pix(1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
      idle(3);
      expect_ev(1'b1, 1'b1, 4'h1, 1'b0);
      sof();
      idle(2);
      check("floor_phase", {30'd0, phase}, 32'd2);
      check("floor_edge", {28'd0, collisionEdge}, 32'h1);
      check("floor_drain", q.size(), 32'd0);

      // Score edge detection across frames N..N+3
      restart();
      pix(1'b1, 4'h0, 1'b0, 1'b0, 1'b1); idle(2);
      expect_ev(1'b0, 1'b0, 4'h0, 1'b1);
      sof();
      pix(1'b1, 4'h0, 1'b0, 1'b0, 1'b1); idle(2);
      sof();
      idle(3);
      sof();
      pix(1'b1, 4'h0, 1'b0, 1'b0, 1'b1); idle(2);
      expect_ev(1'b0, 1'b0, 4'h0, 1'b1);
      sof();
      sof();
      idle(2);
      check("score_drain", q.size(), 32'd0);
      check("score_phase", {30'd0, phase}, 32'd1);

      // Pipe drawn without the bird: nothing
      repeat (10) pix(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      sof();
      idle(2);
      check("nobird_phase", {30'd0, phase}, 32'd1);

      // Score plus crash in one frame: crash only
      pix(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
      repeat (5) pix(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      expect_ev(1'b1, 1'b0, 4'h2, 1'b0);
      sof();
      idle(2);
      check("score_crash_drain", q.size(), 32'd0);
      check("score_crash_phase", {30'd0, phase}, 32'd2);

      // 256 overlaps: a wrapping counter would read 0 and miss the crash
      restart();
      repeat (256) pix(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      expect_ev(1'b1, 1'b0, 4'h2, 1'b0);
      sof();
      idle(3);
      check("sat_drain", q.size(), 32'd0);
      check("sat_phase", {30'd0, phase}, 32'd2);

      // Async reset mid-frame
      restart();
      repeat (3) pix(1'b1, 4'h8, 1'b1, 1'b0, 1'b1);
      resetN = 1'b0;
      #1;
      check("arst_phase", {30'd0, phase}, 32'd0);
      check("arst_edge", {28'd0, collisionEdge}, 32'd0);
      check("arst_collision", {31'd0, collision}, 32'd0);
      idle(2);
      resetN = 1'b1;
      idle(1);
      check("arst_held_idle", {30'd0, phase}, 32'd0);

      idle(3);
      check("final_drain", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
